trdb_filter_multi: RTL and testbench

- Parametrised successor of the trace-encoder filter stage.
- Qualifies each retired instruction against N programmable address ranges and an optional privilege match.
- Each range is independently configured as a qualify window, a start trigger or a stop trigger.
- A start/stop trigger FSM gates tracing and requests deactivation. Sits between the core-interface sampling stage and the packet-emission logic; outputs are registered.

---
 rtl/trdb_filter_multi.sv | 173 +++++++++++++++++
 tb/tb_trdb_filter_multi.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_filter_multi.sv
`timescale 1ns/1ps
// Trace-encoder filter stage: N address comparators (qualify/start/stop) plus a privilege match
// and a start/stop trigger FSM. Optional per-range hit counters: define TRDB_FILTER_HITCNT_EN.
module trdb_filter_multi #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned N_RANGES = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic [XLEN-1:0]              iaddr_i,
  input  logic [1:0]                   priv_lvl_i,
  input  logic                         trace_activated_i,
  input  logic                         apply_filters_i,
  input  logic                         trace_selected_priv_i,
  input  logic [1:0]                   which_priv_i,
  input  logic [N_RANGES-1:0]          range_en_i,
  input  logic [2*N_RANGES-1:0]        range_mode_i,
  input  logic [N_RANGES*XLEN-1:0]     range_lower_i,
  input  logic [N_RANGES*XLEN-1:0]     range_upper_i,
  input  logic                         stop_deactivate_i,
  input  logic                         cnt_clr_i,
  output logic                         valid_o,
  output logic                         trace_range_match_o,
  output logic                         trace_priv_match_o,
  output logic                         trace_qualified_o,
  output logic                         trace_req_deactivate_o,
  output logic [N_RANGES*CNT_W-1:0]    hit_cnt_o
);

  localparam logic [1:0] MODE_QUAL  = 2'b00;
  localparam logic [1:0] MODE_START = 2'b01;
  localparam logic [1:0] MODE_STOP  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE       = 2'b00,
    S_WAIT_START = 2'b01,
    S_RUN        = 2'b10,
    S_STOPPED    = 2'b11
  } state_e;

  state_e              r_state;
  logic                r_valid;
  logic                r_range_match;
  logic                r_priv_match;
  logic                r_qualified;
  logic                r_req_deact;

  logic [N_RANGES-1:0] w_hit;
  logic                w_any_qual_en;
  logic                w_any_start_en;
  logic                w_qual_hit;
  logic                w_start_hit;
  logic                w_stop_hit;
  logic                w_range_match;
  logic                w_priv_match;
  logic                w_eligible;
  logic                w_filter_ok;

  // Range comparators and per-mode reduction; reserved-mode ranges never hit.
  always_comb begin
    w_hit          = '0;
    w_any_qual_en  = 1'b0;
    w_any_start_en = 1'b0;
    w_qual_hit     = 1'b0;
    w_start_hit    = 1'b0;
    w_stop_hit     = 1'b0;
    for (int i = 0; i < N_RANGES; i++) begin
      if (range_en_i[i] && (range_mode_i[2*i +: 2] != 2'b11) &&
          (range_lower_i[i*XLEN +: XLEN] <= iaddr_i) &&
          (iaddr_i <= range_upper_i[i*XLEN +: XLEN])) begin
        w_hit[i] = 1'b1;
      end else begin
        w_hit[i] = 1'b0;
      end
      case (range_mode_i[2*i +: 2])
        MODE_QUAL: begin
          w_any_qual_en = w_any_qual_en | range_en_i[i];
          w_qual_hit    = w_qual_hit | w_hit[i];
        end
        MODE_START: begin
          w_any_start_en = w_any_start_en | range_en_i[i];
          w_start_hit    = w_start_hit | w_hit[i];
        end
        MODE_STOP: w_stop_hit = w_stop_hit | w_hit[i];
        default:   w_stop_hit = w_stop_hit;
      endcase
    end
  end

  // Match results and trigger eligibility of the current instruction.
  always_comb begin
    w_range_match = w_any_qual_en ? w_qual_hit : 1'b1;
    w_priv_match  = !trace_selected_priv_i || (priv_lvl_i == which_priv_i);
    case (r_state)
      S_RUN:        w_eligible = 1'b1;
      S_WAIT_START: w_eligible = w_start_hit;
      default:      w_eligible = 1'b0;
    endcase
    if (apply_filters_i) begin
      w_filter_ok = w_range_match & w_priv_match & w_eligible;
    end else begin
      w_filter_ok = 1'b1;
    end
  end

  // Trigger FSM and registered outputs; deactivation to IDLE overrides the apply hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_valid       <= 1'b0;
      r_range_match <= 1'b0;
      r_priv_match  <= 1'b0;
      r_qualified   <= 1'b0;
      r_req_deact   <= 1'b0;
    end else begin
      r_valid       <= valid_i;
      r_range_match <= valid_i & w_range_match;
      r_priv_match  <= valid_i & w_priv_match;
      r_qualified   <= trace_activated_i & valid_i & w_filter_ok;
      r_req_deact   <= 1'b0;
      if (!trace_activated_i) begin
        r_state <= S_IDLE;
      end else if (apply_filters_i) begin
        case (r_state)
          S_IDLE:       r_state <= w_any_start_en ? S_WAIT_START : S_RUN;
          S_WAIT_START: if (valid_i && w_start_hit) r_state <= S_RUN;
          S_RUN: begin
            if (valid_i && w_stop_hit) begin
              r_state     <= S_STOPPED;
              r_req_deact <= stop_deactivate_i;
            end
          end
          S_STOPPED:    r_state <= S_STOPPED;
          default:      r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign valid_o                = r_valid;
  assign trace_range_match_o    = r_range_match;
  assign trace_priv_match_o     = r_priv_match;
  assign trace_qualified_o      = r_qualified;
  assign trace_req_deactivate_o = r_req_deact;

`ifdef TRDB_FILTER_HITCNT_EN
  logic [CNT_W-1:0] r_hit_cnt [N_RANGES];

  // Saturating per-range hit counters; clear wins over increment.
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      for (int i = 0; i < N_RANGES; i++) r_hit_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_RANGES; i++) begin
        if (valid_i && w_hit[i] && (r_hit_cnt[i] != {CNT_W{1'b1}})) begin
          r_hit_cnt[i] <= r_hit_cnt[i] + CNT_W'(1'b1);
        end
      end
    end
  end

  for (genvar g = 0; g < N_RANGES; g++) begin : g_cnt_out
    assign hit_cnt_o[g*CNT_W +: CNT_W] = r_hit_cnt[g];
  end
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr_i;
  assign hit_cnt_o        = '0;
`endif

endmodule

// File: tb/tb_trdb_filter_multi.sv
`timescale 1ns/1ps
// Self-checking bench for trdb_filter_multi: directed test-plan scenarios, then random traffic
// against a flag-based reference model of trigger gating and hit counting.
module tb_trdb_filter_multi;
  localparam int XLEN = 32;
  localparam int NR   = 4;
`ifdef TRDB_FILTER_HITCNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  logic               clk = 1'b0;
  logic               rst_i, valid_i, trace_activated_i, apply_filters_i;
  logic               trace_selected_priv_i, stop_deactivate_i, cnt_clr_i;
  logic [XLEN-1:0]    iaddr_i;
  logic [1:0]         priv_lvl_i, which_priv_i;
  logic [NR-1:0]      range_en_i;
  logic [2*NR-1:0]    range_mode_i;
  logic [NR*XLEN-1:0] range_lower_i, range_upper_i;
  logic               valid_o, trace_range_match_o, trace_priv_match_o;
  logic               trace_qualified_o, trace_req_deactivate_o;
  logic [NR*CNT_W-1:0] hit_cnt_o;

  always #5 clk = ~clk;

  trdb_filter_multi #(.XLEN(XLEN), .N_RANGES(NR), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .iaddr_i(iaddr_i),
    .priv_lvl_i(priv_lvl_i), .trace_activated_i(trace_activated_i),
    .apply_filters_i(apply_filters_i), .trace_selected_priv_i(trace_selected_priv_i),
    .which_priv_i(which_priv_i), .range_en_i(range_en_i), .range_mode_i(range_mode_i),
    .range_lower_i(range_lower_i), .range_upper_i(range_upper_i),
    .stop_deactivate_i(stop_deactivate_i), .cnt_clr_i(cnt_clr_i), .valid_o(valid_o),
    .trace_range_match_o(trace_range_match_o), .trace_priv_match_o(trace_priv_match_o),
    .trace_qualified_o(trace_qualified_o), .trace_req_deactivate_o(trace_req_deactivate_o),
    .hit_cnt_o(hit_cnt_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: live = left IDLE, started = start condition satisfied, stopped = stop seen.
  bit          m_live, m_started, m_stopped;
  int unsigned m_cnt [NR];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit range_hit(input int i);
    longint unsigned lo, hi, a;
    lo = range_lower_i[i*XLEN +: XLEN];
    hi = range_upper_i[i*XLEN +: XLEN];
    a  = iaddr_i;
    return range_en_i[i] && (range_mode_i[2*i +: 2] != 2'b11) && (lo <= a) && (a <= hi);
  endfunction

  task automatic step();
    bit any_q = 0, qh = 0, any_s = 0, sh = 0, th = 0;
    bit rm, pm, elig;
    bit e_valid = 0, e_range = 0, e_priv = 0, e_qual = 0, e_deact = 0;
    int unsigned cmax = (1 << CNT_W) - 1;
    for (int i = 0; i < NR; i++) begin
      case (range_mode_i[2*i +: 2])
        2'b00: begin any_q |= range_en_i[i]; qh |= range_hit(i); end
        2'b01: begin any_s |= range_en_i[i]; sh |= range_hit(i); end
        2'b10: th |= range_hit(i);
        default: ;
      endcase
    end
    if (rst_i) begin
      m_live = 0; m_started = 0; m_stopped = 0;
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    end else begin
      rm   = any_q ? qh : 1'b1;
      pm   = !trace_selected_priv_i || (priv_lvl_i == which_priv_i);
      elig = m_live && !m_stopped && (m_started || (valid_i && sh));
      e_valid = valid_i;
      e_range = valid_i && rm;
      e_priv  = valid_i && pm;
      e_qual  = trace_activated_i && valid_i && (apply_filters_i ? (rm && pm && elig) : 1'b1);
      if (!trace_activated_i) begin
        m_live = 0; m_started = 0; m_stopped = 0;
      end else if (apply_filters_i) begin
        if (!m_live) begin
          m_live = 1; m_started = !any_s; m_stopped = 0;
        end else if (valid_i && !m_started && sh) begin
          m_started = 1;
        end else if (valid_i && m_started && !m_stopped && th) begin
          m_stopped = 1;
          e_deact   = stop_deactivate_i;
        end
      end
`ifdef TRDB_FILTER_HITCNT_EN
      for (int i = 0; i < NR; i++) begin
        if (cnt_clr_i) m_cnt[i] = 0;
        else if (valid_i && range_hit(i) && m_cnt[i] < cmax) m_cnt[i]++;
      end
`endif
    end
    @(posedge clk);
    #1;
    check("valid_o", valid_o, e_valid);
    check("range_match", trace_range_match_o, e_range);
    check("priv_match", trace_priv_match_o, e_priv);
    check("qualified", trace_qualified_o, e_qual);
    check("req_deact", trace_req_deactivate_o, e_deact);
    for (int i = 0; i < NR; i++) check("hit_cnt", hit_cnt_o[i*CNT_W +: CNT_W], m_cnt[i]);
  endtask

  task automatic set_range(input int i, input bit en, input logic [1:0] mode,
                           input logic [XLEN-1:0] lo, input logic [XLEN-1:0] hi);
    range_en_i[i]                = en;
    range_mode_i[2*i +: 2]       = mode;
    range_lower_i[i*XLEN +: XLEN] = lo;
    range_upper_i[i*XLEN +: XLEN] = hi;
  endtask

  task automatic clear_ranges();
    for (int i = 0; i < NR; i++) set_range(i, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic randomize_inputs();
    valid_i = 1'($urandom); iaddr_i = $urandom; priv_lvl_i = 2'($urandom);
    trace_activated_i = 1'($urandom); apply_filters_i = 1'($urandom);
    trace_selected_priv_i = 1'($urandom); which_priv_i = 2'($urandom);
    stop_deactivate_i = 1'($urandom); cnt_clr_i = 1'($urandom);
    range_en_i = 4'($urandom); range_mode_i = 8'($urandom);
    for (int i = 0; i < NR; i++) begin
      range_lower_i[i*XLEN +: XLEN] = $urandom;
      range_upper_i[i*XLEN +: XLEN] = $urandom;
    end
  endtask

  logic [XLEN-1:0] tp3_addr [5] = '{32'h80, 32'h100, 32'h150, 32'h200, 32'h250};
  logic            tp3_q    [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic            tp3_d    [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [1:0]      tp4_p    [3] = '{2'd3, 2'd0, 2'd3};
  logic            tp4_m    [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    // Reset held 3 cycles with inputs toggling, then released with valid_i low.
    rst_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      randomize_inputs();
      step();
      check("rst_qual", trace_qualified_o, 1'b0);
    end
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      randomize_inputs();
      valid_i = 1'b0;
      step();
      check("post_rst_valid", valid_o, 1'b0);
    end

    valid_i = 1'b0; trace_activated_i = 1'b0; apply_filters_i = 1'b1;
    trace_selected_priv_i = 1'b0; which_priv_i = 2'd0; priv_lvl_i = 2'd0;
    stop_deactivate_i = 1'b0; cnt_clr_i = 1'b0; iaddr_i = 32'h0;
    clear_ranges();
    step();

    // Qualify window boundary.
    set_range(0, 1'b1, 2'b00, 32'h1000, 32'h1FFF);
    trace_activated_i = 1'b1;
    step();
    valid_i = 1'b1; iaddr_i = 32'h1FFF; step(); check("tp2_in", trace_qualified_o, 1'b1);
    iaddr_i = 32'h2000;                 step(); check("tp2_out", trace_qualified_o, 1'b0);
    valid_i = 1'b0;

    // Start/stop triggers.
    trace_activated_i = 1'b0; step();
    clear_ranges();
    set_range(1, 1'b1, 2'b01, 32'h100, 32'h100);
    set_range(2, 1'b1, 2'b10, 32'h200, 32'h200);
    stop_deactivate_i = 1'b1; trace_activated_i = 1'b1;
    step();
    valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      iaddr_i = tp3_addr[k];
      step();
      check("tp3_q", trace_qualified_o, tp3_q[k]);
      check("tp3_deact", trace_req_deactivate_o, tp3_d[k]);
    end
    valid_i = 1'b0; step(); check("tp3_deact_once", trace_req_deactivate_o, 1'b0);

    // Privilege filter.
    trace_activated_i = 1'b0; step();
    clear_ranges(); stop_deactivate_i = 1'b0;
    trace_activated_i = 1'b1; step();
    trace_selected_priv_i = 1'b1; which_priv_i = 2'd3; valid_i = 1'b1; iaddr_i = 32'h40;
    for (int k = 0; k < 3; k++) begin
      priv_lvl_i = tp4_p[k];
      step();
      check("tp4_priv", trace_priv_match_o, tp4_m[k]);
      check("tp4_q", trace_qualified_o, tp4_m[k]);
    end

    // Filter bypass holds the trigger state.
    valid_i = 1'b0; trace_selected_priv_i = 1'b0; trace_activated_i = 1'b0; step();
    set_range(0, 1'b1, 2'b00, 32'h1000, 32'h1FFF);
    set_range(1, 1'b1, 2'b01, 32'h100, 32'h100);
    trace_activated_i = 1'b1; step();
    apply_filters_i = 1'b0; valid_i = 1'b1; iaddr_i = 32'h100;
    step(); check("tp5_byp_q", trace_qualified_o, 1'b1); check("tp5_byp_rm", trace_range_match_o, 1'b0);
    apply_filters_i = 1'b1; iaddr_i = 32'h1500;
    step(); check("tp5_hold", trace_qualified_o, 1'b0);
    iaddr_i = 32'h100;  step(); check("tp5_start", trace_qualified_o, 1'b0);
    iaddr_i = 32'h1000; step(); check("tp5_run", trace_qualified_o, 1'b1);

`ifdef TRDB_FILTER_HITCNT_EN
    // Saturation and clear priority.
    valid_i = 1'b0; clear_ranges();
    set_range(0, 1'b1, 2'b00, 32'h10, 32'h20);
    cnt_clr_i = 1'b1; step(); cnt_clr_i = 1'b0;
    valid_i = 1'b1; iaddr_i = 32'h10;
    for (int k = 0; k < 5; k++) step();
    check("tp6_sat", hit_cnt_o[CNT_W-1:0], 3);
    cnt_clr_i = 1'b1; step(); check("tp6_clr", hit_cnt_o[CNT_W-1:0], 0);
    cnt_clr_i = 1'b0;
`endif

    // Random traffic in a small address space so ranges hit often.
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(199) == 0);
      if ($urandom_range(49) == 0) trace_activated_i = ~trace_activated_i;
      apply_filters_i = ($urandom_range(7) != 0);
      valid_i = ($urandom_range(3) != 0);
      iaddr_i = 32'($urandom_range(63));
      priv_lvl_i = 2'($urandom);
      cnt_clr_i = ($urandom_range(49) == 0);
      if ($urandom_range(29) == 0) begin
        trace_selected_priv_i = 1'($urandom);
        which_priv_i = 2'($urandom);
        stop_deactivate_i = 1'($urandom);
        for (int i = 0; i < NR; i++) begin
          logic [XLEN-1:0] lo;
          lo = 32'($urandom_range(63));
          set_range(i, 1'($urandom), 2'($urandom), lo,
                    ($urandom_range(7) == 0) ? 32'($urandom_range(63)) : lo + 32'($urandom_range(15)));
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
